// File: rtl/ring_counter_phase_monitor.sv
// ring_counter_phase_monitor
//
// Purpose:
//   Sits directly downstream of a 16-bit one-hot ring counter. It samples the
//   counter value, running flag and output enable on every rising edge, and
//   encodes the active phase into a 4-bit index. It also pulses on every
//   bit15 -> bit0 wrap, keeps a saturating count of completed revolutions and
//   latches the first sequencing fault it sees.
//
// Parameters:
//   REV_COUNT_WIDTH  width of the saturating revolution counter (>= 2)
//   CHECK_STEP       1: any one-hot jump other than rotate-left-by-one is a fault
//                    0: such a jump silently resynchronises to the new phase
//
// Ports:
//   Clk_In                    rising-edge clock (same net as the ring counter)
//   Reset_N_In                synchronous active-low reset
//   Ring_Value_In[15:0]       ring counter one-hot value
//   Ring_Running_In           ring counter running flag
//   Ring_Valid_In             ring counter output enable; value/running ignored when low
//   Clear_Command_In          synchronous clear of counts and errors, back to IDLE
//   Phase_Index_Out[3:0]      index of the set bit in the last accepted sample
//   Phase_Valid_Out           Phase_Index_Out is current
//   Wrap_Pulse_Out            one-cycle pulse on an accepted bit15 -> bit0 advance
//   Revolution_Count_Out      saturating number of wraps since reset/clear
//   Revolution_Saturated_Out  revolution count has reached all-ones
//   Error_Flag_Out            sticky fault indicator
//   Error_Code_Out[1:0]       first fault: 00 none, 01 not one-hot,
//                             10 illegal step, 11 advance while stopped

module ring_counter_phase_monitor #(
  parameter int unsigned REV_COUNT_WIDTH = 8,
  parameter bit          CHECK_STEP      = 1'b1
) (
  input  logic                       Clk_In,
  input  logic                       Reset_N_In,
  input  logic [15:0]                Ring_Value_In,
  input  logic                       Ring_Running_In,
  input  logic                       Ring_Valid_In,
  input  logic                       Clear_Command_In,
  output logic [3:0]                 Phase_Index_Out,
  output logic                       Phase_Valid_Out,
  output logic                       Wrap_Pulse_Out,
  output logic [REV_COUNT_WIDTH-1:0] Revolution_Count_Out,
  output logic                       Revolution_Saturated_Out,
  output logic                       Error_Flag_Out,
  output logic [1:0]                 Error_Code_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } monitorState_t;

  localparam logic [1:0] ErrNotOneHot   = 2'b01;
  localparam logic [1:0] ErrIllegalStep = 2'b10;
  localparam logic [1:0] ErrStoppedAdv  = 2'b11;

  localparam logic [REV_COUNT_WIDTH-1:0] RevOne = {{(REV_COUNT_WIDTH-1){1'b0}}, 1'b1};

  monitorState_t state_q, state_d;
  logic [15:0]                prevValue_q, prevValue_d;
  logic                       prevRunning_q, prevRunning_d;
  logic [3:0]                 phaseIndex_q, phaseIndex_d;
  logic                       phaseValid_q, phaseValid_d;
  logic                       wrapPulse_q, wrapPulse_d;
  logic [REV_COUNT_WIDTH-1:0] revCount_q, revCount_d;
  logic                       revSat_q, revSat_d;
  logic                       errorFlag_q, errorFlag_d;
  logic [1:0]                 errorCode_q, errorCode_d;

  logic [3:0]  sampleIndex;
  logic [4:0]  bitCount;
  logic        sampleOneHot;
  logic [15:0] rotatedPrev;

  // Encode the incoming sample: population count decides one-hot-ness and the
  // highest set bit gives the index (only meaningful when exactly one is set).
  always_comb begin
    sampleIndex = 4'd0;
    bitCount    = 5'd0;
    for (int b = 0; b < 16; b++) begin
      if (Ring_Value_In[b]) begin
        sampleIndex = 4'(b);
        bitCount    = bitCount + 5'd1;
      end
    end
  end

  assign sampleOneHot = (bitCount == 5'd1);
  assign rotatedPrev  = {prevValue_q[14:0], prevValue_q[15]};

  // Next-state logic. The wrap pulse is a one-cycle event, so it defaults low;
  // everything else holds unless the current state decides otherwise.
  always_comb begin
    state_d       = state_q;
    prevValue_d   = prevValue_q;
    prevRunning_d = prevRunning_q;
    phaseIndex_d  = phaseIndex_q;
    phaseValid_d  = phaseValid_q;
    wrapPulse_d   = 1'b0;
    revCount_d    = revCount_q;
    errorFlag_d   = errorFlag_q;
    errorCode_d   = errorCode_q;

    unique case (state_q)
      IDLE: begin
        if (Ring_Valid_In) begin
          prevRunning_d = Ring_Running_In;
          if (sampleOneHot) begin
            state_d      = TRACK;
            prevValue_d  = Ring_Value_In;
            phaseIndex_d = sampleIndex;
            phaseValid_d = 1'b1;
          end else begin
            state_d      = FAULT;
            phaseValid_d = 1'b0;
            errorFlag_d  = 1'b1;
            errorCode_d  = ErrNotOneHot;
          end
        end
      end

      TRACK: begin
        if (Ring_Valid_In) begin
          prevRunning_d = Ring_Running_In;
          if (!sampleOneHot) begin
            state_d      = FAULT;
            phaseValid_d = 1'b0;
            errorFlag_d  = 1'b1;
            errorCode_d  = ErrNotOneHot;
          end else if (Ring_Value_In == prevValue_q) begin
            phaseValid_d = 1'b1;
          end else if (Ring_Value_In == rotatedPrev) begin
            prevValue_d  = Ring_Value_In;
            phaseIndex_d = sampleIndex;
            // The stop command drops running on the final shift, so an advance
            // is only suspicious when neither sample claims to be running.
            if (!Ring_Running_In && !prevRunning_q) begin
              state_d      = FAULT;
              phaseValid_d = 1'b0;
              errorFlag_d  = 1'b1;
              errorCode_d  = ErrStoppedAdv;
            end else begin
              phaseValid_d = 1'b1;
              if (prevValue_q[15]) begin
                wrapPulse_d = 1'b1;
                if (revCount_q != {REV_COUNT_WIDTH{1'b1}}) begin
                  revCount_d = revCount_q + RevOne;
                end
              end
            end
          end else if (CHECK_STEP) begin
            state_d      = FAULT;
            phaseValid_d = 1'b0;
            errorFlag_d  = 1'b1;
            errorCode_d  = ErrIllegalStep;
          end else begin
            prevValue_d  = Ring_Value_In;
            phaseIndex_d = sampleIndex;
            phaseValid_d = 1'b1;
          end
        end else begin
          phaseValid_d = 1'b0;
        end
      end

      FAULT: begin
        phaseValid_d = 1'b0;
      end

      default: begin
        state_d      = IDLE;
        phaseValid_d = 1'b0;
      end
    endcase

    revSat_d = &revCount_d;
  end

  // State register. A clear is a synchronous reset that also discards the
  // sample presented on the same edge.
  always_ff @(posedge Clk_In) begin
    if (!Reset_N_In || Clear_Command_In) begin
      state_q       <= IDLE;
      prevValue_q   <= 16'd0;
      prevRunning_q <= 1'b0;
      phaseIndex_q  <= 4'd0;
      phaseValid_q  <= 1'b0;
      wrapPulse_q   <= 1'b0;
      revCount_q    <= '0;
      revSat_q      <= 1'b0;
      errorFlag_q   <= 1'b0;
      errorCode_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      prevValue_q   <= prevValue_d;
      prevRunning_q <= prevRunning_d;
      phaseIndex_q  <= phaseIndex_d;
      phaseValid_q  <= phaseValid_d;
      wrapPulse_q   <= wrapPulse_d;
      revCount_q    <= revCount_d;
      revSat_q      <= revSat_d;
      errorFlag_q   <= errorFlag_d;
      errorCode_q   <= errorCode_d;
    end
  end

  assign Phase_Index_Out          = phaseIndex_q;
  assign Phase_Valid_Out          = phaseValid_q;
  assign Wrap_Pulse_Out           = wrapPulse_q;
  assign Revolution_Count_Out     = revCount_q;
  assign Revolution_Saturated_Out = revSat_q;
  assign Error_Flag_Out           = errorFlag_q;
  assign Error_Code_Out           = errorCode_q;

endmodule

// File: tb/tb_ring_counter_phase_monitor.sv
// Testbench for ring_counter_phase_monitor.
// Three instances share the same stimulus: the default configuration, one with
// CHECK_STEP=0 and one with a 2-bit revolution counter.

module tb_ring_counter_phase_monitor;

  typedef struct packed {
    logic [3:0] idx;
    logic       pv;
    logic       wrap;
    logic [7:0] cnt;
    logic       sat;
    logic       err;
    logic [1:0] code;
  } expT;

  typedef struct {
    string       name;
    logic        rstN;
    logic        clr;
    logic        vld;
    logic        run;
    logic [15:0] val;
    expT         exp;
  } vecT;

  logic        clk = 1'b0;
  logic        rstN, clr, vld, run;
  logic [15:0] val;

  logic [3:0] mIdx, nIdx, sIdx;
  logic       mPv, nPv, sPv, mWrap, nWrap, sWrap;
  logic [7:0] mCnt, nCnt;
  logic [1:0] sCnt;
  logic       mSat, nSat, sSat, mErr, nErr, sErr;
  logic [1:0] mCode, nCode, sCode;

  expT sbQueue[$];
  vecT vectors[$];
  int  checks   = 0;
  int  failures = 0;
  int  satWraps = 0;

  always #5 clk = ~clk;

  ring_counter_phase_monitor #(.REV_COUNT_WIDTH(8), .CHECK_STEP(1'b1)) dutMain (
    .Clk_In(clk), .Reset_N_In(rstN), .Ring_Value_In(val), .Ring_Running_In(run),
    .Ring_Valid_In(vld), .Clear_Command_In(clr), .Phase_Index_Out(mIdx),
    .Phase_Valid_Out(mPv), .Wrap_Pulse_Out(mWrap), .Revolution_Count_Out(mCnt),
    .Revolution_Saturated_Out(mSat), .Error_Flag_Out(mErr), .Error_Code_Out(mCode)
  );

  ring_counter_phase_monitor #(.REV_COUNT_WIDTH(8), .CHECK_STEP(1'b0)) dutNoStep (
    .Clk_In(clk), .Reset_N_In(rstN), .Ring_Value_In(val), .Ring_Running_In(run),
    .Ring_Valid_In(vld), .Clear_Command_In(clr), .Phase_Index_Out(nIdx),
    .Phase_Valid_Out(nPv), .Wrap_Pulse_Out(nWrap), .Revolution_Count_Out(nCnt),
    .Revolution_Saturated_Out(nSat), .Error_Flag_Out(nErr), .Error_Code_Out(nCode)
  );

  ring_counter_phase_monitor #(.REV_COUNT_WIDTH(2), .CHECK_STEP(1'b1)) dutSat (
    .Clk_In(clk), .Reset_N_In(rstN), .Ring_Value_In(val), .Ring_Running_In(run),
    .Ring_Valid_In(vld), .Clear_Command_In(clr), .Phase_Index_Out(sIdx),
    .Phase_Valid_Out(sPv), .Wrap_Pulse_Out(sWrap), .Revolution_Count_Out(sCnt),
    .Revolution_Saturated_Out(sSat), .Error_Flag_Out(sErr), .Error_Code_Out(sCode)
  );

  // Expected-output record for the default instance (it never saturates here).
  function automatic expT mk(input logic [3:0] idx, input logic pv, input logic wrap,
                             input logic [7:0] cnt, input logic err, input logic [1:0] code);
    expT e;
    e.idx  = idx;
    e.pv   = pv;
    e.wrap = wrap;
    e.cnt  = cnt;
    e.sat  = 1'b0;
    e.err  = err;
    e.code = code;
    return e;
  endfunction

  function automatic vecT mkVec(input string name, input logic r, input logic c, input logic v,
                                input logic rn, input logic [15:0] value, input expT e);
    vecT x;
    x.name = name;
    x.rstN = r;
    x.clr  = c;
    x.vld  = v;
    x.run  = rn;
    x.val  = value;
    x.exp  = e;
    return x;
  endfunction

  // Drive one sample on the falling edge, as the ring counter would, and queue
  // what the default instance should show after the next rising edge.
  task automatic applyStimulus(input vecT v);
    @(negedge clk);
    rstN = v.rstN;
    clr  = v.clr;
    vld  = v.vld;
    run  = v.run;
    val  = v.val;
    sbQueue.push_back(v.exp);
  endtask

  // Pop the scoreboard and compare just after the rising edge.
  task automatic checkOutput(input string name);
    expT got;
    expT want;
    @(posedge clk);
    #1;
    got = {mIdx, mPv, mWrap, mCnt, mSat, mErr, mCode};
    checks++;
    if (sbQueue.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      want = sbQueue.pop_front();
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL %s: got idx=%0d pv=%0b wrap=%0b cnt=%0d sat=%0b err=%0b code=%0b, want idx=%0d pv=%0b wrap=%0b cnt=%0d sat=%0b err=%0b code=%0b",
                 name, got.idx, got.pv, got.wrap, got.cnt, got.sat, got.err, got.code,
                 want.idx, want.pv, want.wrap, want.cnt, want.sat, want.err, want.code);
      end
    end
  endtask

  task automatic step(input vecT v);
    applyStimulus(v);
    checkOutput(v.name);
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  initial begin
    expT zero;
    zero = mk(4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    rstN = 1'b0;
    clr  = 1'b0;
    vld  = 1'b0;
    run  = 1'b0;
    val  = 16'd0;

    vectors.push_back(mkVec("clr_discard", 1, 1, 1, 1, 16'h0002, zero));
    vectors.push_back(mkVec("nh_track",    1, 0, 1, 1, 16'h0004, mk(2, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("nh_fault",    1, 0, 1, 1, 16'h0006, mk(2, 0, 0, 0, 1, 2'b01)));
    vectors.push_back(mkVec("nh_frozen",   1, 0, 1, 1, 16'h0008, mk(2, 0, 0, 0, 1, 2'b01)));
    vectors.push_back(mkVec("nh_clear",    1, 1, 0, 0, 16'h0000, zero));
    vectors.push_back(mkVec("nh_idle",     1, 0, 0, 0, 16'h0000, zero));
    vectors.push_back(mkVec("step_track",  1, 0, 1, 1, 16'h0020, mk(5, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("step_fault",  1, 0, 1, 1, 16'h0001, mk(5, 0, 0, 0, 1, 2'b10)));
    vectors.push_back(mkVec("step_clear",  1, 1, 0, 0, 16'h0000, zero));
    vectors.push_back(mkVec("stop_first",  1, 0, 1, 0, 16'h0002, mk(1, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("stop_fault",  1, 0, 1, 0, 16'h0004, mk(2, 0, 0, 0, 1, 2'b11)));
    vectors.push_back(mkVec("stop_clear",  1, 1, 0, 0, 16'h0000, zero));
    vectors.push_back(mkVec("run_first",   1, 0, 1, 1, 16'h0002, mk(1, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("run_drop",    1, 0, 1, 0, 16'h0004, mk(2, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("run_hold",    1, 0, 1, 0, 16'h0004, mk(2, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("gate_clear",  1, 1, 0, 0, 16'h0000, zero));
    vectors.push_back(mkVec("gate_a",      1, 0, 1, 1, 16'h0080, mk(7, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("gate_b",      1, 0, 1, 1, 16'h0100, mk(8, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("gate_off0",   1, 0, 0, 1, 16'h0100, mk(8, 0, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("gate_off1",   1, 0, 0, 1, 16'h0100, mk(8, 0, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("gate_off2",   1, 0, 0, 1, 16'h0100, mk(8, 0, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("gate_on",     1, 0, 1, 1, 16'h0200, mk(9, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("pri_clear",   1, 1, 0, 0, 16'h0000, zero));
    vectors.push_back(mkVec("pri_a",       1, 0, 1, 1, 16'h4000, mk(14, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("pri_b",       1, 0, 1, 1, 16'h8000, mk(15, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("pri_reset",   0, 1, 1, 1, 16'h0001, zero));
    vectors.push_back(mkVec("pri_c",       1, 0, 1, 1, 16'h4000, mk(14, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("pri_d",       1, 0, 1, 1, 16'h8000, mk(15, 1, 0, 0, 0, 2'b00)));
    vectors.push_back(mkVec("pri_clrwrap", 1, 1, 1, 1, 16'h0001, zero));
    vectors.push_back(mkVec("pri_after",   1, 0, 1, 1, 16'h0001, mk(0, 1, 0, 0, 0, 2'b00)));

    // Reset, including an edge where clear and a sample are also present.
    step(mkVec("reset",      0, 0, 0, 0, 16'h0000, zero));
    step(mkVec("reset_hold", 0, 1, 1, 1, 16'h0001, zero));
    checkValue("reset_nostep", {nIdx, nPv, nWrap, nCnt, nSat, nErr, nCode}, 32'd0);
    checkValue("reset_sat",    {sIdx, sPv, sWrap, sCnt, sSat, sErr, sCode}, 32'd0);

    // Normal rotation: 40 back-to-back samples starting at bit 0.
    for (int i = 0; i < 40; i++) begin
      step(mkVec($sformatf("rot_%0d", i), 1, 0, 1, 1, 16'(1 << (i % 16)),
                 mk(4'(i % 16), 1'b1, (i > 0) && (i % 16 == 0), 8'(i / 16), 1'b0, 2'b00)));
    end
    checkValue("rot_nostep_cnt", {24'd0, nCnt}, 32'd2);

    for (int i = 0; i < vectors.size(); i++) begin
      step(vectors[i]);
    end

    // Illegal step seen by both configurations of CHECK_STEP.
    step(mkVec("ns_clear", 1, 1, 0, 0, 16'h0000, zero));
    step(mkVec("ns_track", 1, 0, 1, 1, 16'h0020, mk(5, 1, 0, 0, 0, 2'b00)));
    step(mkVec("ns_jump",  1, 0, 1, 1, 16'h0001, mk(5, 0, 0, 0, 1, 2'b10)));
    checkValue("nostep_idx",  {28'd0, nIdx}, 32'd0);
    checkValue("nostep_pv",   {31'd0, nPv}, 32'd1);
    checkValue("nostep_wrap", {31'd0, nWrap}, 32'd0);
    checkValue("nostep_err",  {29'd0, nErr, nCode}, 32'd0);
    checkValue("nostep_cnt",  {24'd0, nCnt}, 32'd0);

    // Five full revolutions: the 2-bit counter saturates but keeps pulsing.
    step(mkVec("sat_clear", 1, 1, 0, 0, 16'h0000, zero));
    for (int i = 0; i <= 80; i++) begin
      step(mkVec($sformatf("sat_rot_%0d", i), 1, 0, 1, 1, 16'(1 << (i % 16)),
                 mk(4'(i % 16), 1'b1, (i > 0) && (i % 16 == 0), 8'(i / 16), 1'b0, 2'b00)));
      if (sWrap) satWraps++;
      if (i == 32) begin
        checkValue("sat_cnt_two",  {30'd0, sCnt}, 32'd2);
        checkValue("sat_flag_low", {31'd0, sSat}, 32'd0);
      end
    end
    checkValue("sat_cnt",     {30'd0, sCnt}, 32'd3);
    checkValue("sat_flag",    {31'd0, sSat}, 32'd1);
    checkValue("sat_wraps",   satWraps, 32'd5);
    checkValue("sat_err",     {29'd0, sErr, sCode}, 32'd0);
    checkValue("sat_big_cnt", {24'd0, nCnt}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
